median_window_ctrl: RTL and testbench

//  Sequential controller that computes a 5-sample sliding-window median of a 6-bit stream.
//  - Holds the last N accepted samples.
//  - Sorts a working copy with one odd-even transposition pass per cycle.
//  - Presents the median on a valid/ready output.
//  - Sits between a sample source and downstream logic; replaces a purely combinational sorter.

---
 rtl/median_window_ctrl_pkg.sv | 9 +
 rtl/median_window_ctrl_sort_pass.sv | 20 ++
 rtl/median_window_ctrl.sv | 104 ++++++++++
 tb/tb_median_window_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/median_window_ctrl_pkg.sv
// Shared types and default sizing for the sliding-window median controller.
package median_pkg;
   localparam int MED_DW = 6;
   localparam int MED_N  = 5;

   typedef logic [MED_DW-1:0] sample_t;

   typedef enum logic [1:0] {FILL, SORT, OUT, WAIT} state_t;
endpackage

// File: rtl/median_window_ctrl_sort_pass.sv
// One odd-even transposition pass over the working copy; parity selects the pairing.
module sort_pass #(
   parameter int DW = 6,
   parameter int N  = 5
) (
   input  logic [N*DW-1:0] work,
   input  logic            parity,
   output logic [N*DW-1:0] result
);
   // Pairs are disjoint within a pass, so every compare reads the unmodified input.
   always_comb begin
      result = work;
      for (int i = 0; i < N-1; i++) begin
         if ((i[0] == parity) && (work[i*DW +: DW] > work[(i+1)*DW +: DW])) begin
            result[i*DW +: DW]     = work[(i+1)*DW +: DW];
            result[(i+1)*DW +: DW] = work[i*DW +: DW];
         end
      end
   end
endmodule

// File: rtl/median_window_ctrl.sv
// Sliding-window median: shift samples into a window, sort a copy one pass per cycle.
// Optional MEDIAN_MINMAX_EN adds registered out_min/out_max alongside the median.
module median_window_ctrl
   import median_pkg::*;
#(
   parameter int DW = MED_DW,
   parameter int N  = MED_N
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_num,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_num,
`ifdef MEDIAN_MINMAX_EN
   output logic [DW-1:0] out_min,
   output logic [DW-1:0] out_max,
`endif
   output logic          busy
);
   localparam int PW = $clog2(N);
   localparam int CW = $clog2(N+1);

   state_t               state, state_nxt;
   logic [N-1:0][DW-1:0] hist, work, win_nxt, pass_out;
   logic [CW-1:0]        fill_cnt;
   logic [PW-1:0]        pass_cnt;
   logic                 accept, last_pass;

   // A sample offered together with clear is dropped even though in_ready reads 1.
   assign accept    = in_valid && in_ready && !clear;
   assign last_pass = (state == SORT) && (pass_cnt == PW'(N-1));
   assign win_nxt   = {hist[N-2:0], in_num};

   sort_pass #(.DW(DW), .N(N)) u_pass (
      .work   (work),
      .parity (pass_cnt[0]),
      .result (pass_out)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= FILL;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FILL: if (accept && fill_cnt == CW'(N-1)) state_nxt = SORT;
         SORT: if (last_pass)                       state_nxt = OUT;
         OUT:  if (out_ready)                       state_nxt = WAIT;
         WAIT: if (accept)                          state_nxt = SORT;
         default:                                   state_nxt = FILL;
      endcase
      if (clear) state_nxt = FILL;
   end

   always_comb begin
      in_ready  = !rst && (state == FILL || state == WAIT);
      out_valid = (state == OUT);
      busy      = (state == SORT || state == OUT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hist     <= '0;
         work     <= '0;
         fill_cnt <= '0;
         pass_cnt <= '0;
         out_num  <= '0;
`ifdef MEDIAN_MINMAX_EN
         out_min  <= '0;
         out_max  <= '0;
`endif
      end else if (clear) begin
         hist     <= '0;
         work     <= '0;
         fill_cnt <= '0;
         pass_cnt <= '0;
      end else begin
         if (accept) begin
            hist <= win_nxt;
            if (state == WAIT || fill_cnt == CW'(N-1)) work <= win_nxt;
            if (state == FILL) fill_cnt <= fill_cnt + 1'b1;
         end
         if (state == SORT) begin
            work <= pass_out;
            if (last_pass) begin
               pass_cnt <= '0;
               out_num  <= pass_out[N/2];
`ifdef MEDIAN_MINMAX_EN
               out_min  <= pass_out[0];
               out_max  <= pass_out[N-1];
`endif
            end else begin
               pass_cnt <= pass_cnt + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_median_window_ctrl.sv
// Directed bench for median_window_ctrl with hand-computed medians.
module tb_median_window_ctrl;
   logic       clk = 1'b0;
   logic       rst, clear, in_valid, out_ready;
   logic [5:0] in_num;
   logic       in_ready, out_valid, busy;
   logic [5:0] out_num;
`ifdef MEDIAN_MINMAX_EN
   logic [5:0] out_min, out_max;
`endif

   integer checks = 0;
   integer errors = 0;

   median_window_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_num    (in_num),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_num   (out_num),
`ifdef MEDIAN_MINMAX_EN
      .out_min   (out_min),
      .out_max   (out_max),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input integer got, input integer exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [5:0] v);
      int n = 0;
      in_valid = 1'b1;
      in_num   = v;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("send_timeout", 0, 1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Waits for out_valid; reports cycles waited and how often in_ready was seen high.
   task automatic wait_out(input string tag, output int cyc, output int rdy_hi);
      cyc = 0;
      rdy_hi = 0;
      while (!out_valid && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (in_ready && !out_valid) rdy_hi++;
      end
      chk({tag, "_vld"}, out_valid, 1);
   endtask

   task automatic idle_none(input string tag, input int n);
      int seen = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk(tag, seen, 0);
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   initial begin
      int cyc, rdy;
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_num = '0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_num", out_num, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);
      @(negedge clk);

      // Window fills newest-first; sorted {1,2,3,4,5}
      send(5); send(1); send(4); send(2); send(3);
      wait_out("t1", cyc, rdy);
      chk("t1_latency", cyc, 5);
      chk("t1_in_ready_busy", rdy, 0);
      chk("t1_med", out_num, 3);
`ifdef MEDIAN_MINMAX_EN
      chk("t1_min", out_min, 1);
      chk("t1_max", out_max, 5);
`endif
      @(negedge clk);
      chk("t1_wait_ready", in_ready, 1);

      // Window {0,3,2,4,1}
      send(0);
      chk("t2_busy", busy, 1);
      wait_out("t2", cyc, rdy);
      chk("t2_in_ready_busy", rdy, 0);
      chk("t2_med", out_num, 2);
      @(negedge clk);

      // Ties and extremes from an empty window
      pulse_clear();
      send(63); send(63); send(0); send(63); send(0);
      wait_out("t3", cyc, rdy);
      chk("t3_med", out_num, 63);
`ifdef MEDIAN_MINMAX_EN
      chk("t3_min", out_min, 0);
      chk("t3_max", out_max, 63);
`endif
      @(negedge clk);

      // Back-pressure: window {10,0,63,0,63} -> 10, with a stalled 5 behind it
      out_ready = 1'b0;
      send(10);
      wait_out("t4", cyc, rdy);
      in_valid = 1'b1;
      in_num   = 6'd5;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t4_hold_vld", out_valid, 1);
         chk("t4_hold_num", out_num, 10);
         chk("t4_hold_rdy", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("t4_wait_rdy", in_ready, 1);
      chk("t4_wait_busy", busy, 0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("t4_stalled_taken", busy, 1);
      // {5,10,0,63,0} -> 5
      wait_out("t4b", cyc, rdy);
      chk("t4b_med", out_num, 5);
      @(negedge clk);

      // Reset in the third sort cycle
      send(7);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_out_valid", out_valid, 0);
      chk("t5_out_num", out_num, 0);
      chk("t5_busy", busy, 0);
      chk("t5_in_ready", in_ready, 0);
      rst = 1'b0;
      #1;
      chk("t5_fill_ready", in_ready, 1);
      @(negedge clk);
      send(2); send(9); send(4); send(6);
      idle_none("t5_partial", 8);
      send(1);
      wait_out("t5", cyc, rdy);
      chk("t5_med", out_num, 4);
      @(negedge clk);

      // Clear with three samples loaded; the sample offered alongside clear is dropped
      pulse_clear();
      send(11); send(12); send(13);
      clear = 1'b1; in_valid = 1'b1; in_num = 6'd50;
      #1;
      chk("t6_clr_ready", in_ready, 1);
      @(negedge clk);
      clear = 1'b0; in_valid = 1'b0;
      send(20); send(21);
      idle_none("t6_after_clear", 8);
      pulse_clear();
      send(9); send(7); send(8); send(6); send(10);
      wait_out("t6", cyc, rdy);
      chk("t6_med", out_num, 8);
`ifdef MEDIAN_MINMAX_EN
      chk("t6_min", out_min, 6);
      chk("t6_max", out_max, 10);
`endif
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
